// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared PS/2 set-2 constants, decoder state type and note width
package ps2_kbd_pkg;
    localparam int NOTE_W = 7;
    localparam logic [7:0] PFX_BRK    = 8'hF0;
    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] KEY_OCT_DN = 8'h1A;
    localparam logic [7:0] KEY_OCT_UP = 8'h22;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dec_state_t;

    // Keyboard status/handshake bytes that never belong to a key sequence
    function automatic logic is_ctrl(input logic [7:0] b);
        return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    endfunction
endpackage

// File: rtl/ps2_scancode_to_note.sv
// ps2_scancode_to_note: maps a piano-row scancode to key index 0..12 (code in, hit/idx out)
module ps2_scancode_to_note (
    input  logic [7:0] code,
    output logic       hit,
    output logic [3:0] idx
);
    always_comb begin
        hit = 1'b1;
        idx = 4'd0;
        case (code)
            8'h1C: idx = 4'd0;
            8'h1D: idx = 4'd1;
            8'h1B: idx = 4'd2;
            8'h24: idx = 4'd3;
            8'h23: idx = 4'd4;
            8'h2B: idx = 4'd5;
            8'h2C: idx = 4'd6;
            8'h34: idx = 4'd7;
            8'h35: idx = 4'd8;
            8'h33: idx = 4'd9;
            8'h3C: idx = 4'd10;
            8'h3B: idx = 4'd11;
            8'h42: idx = 4'd12;
            default: hit = 1'b0;
        endcase
    end
endmodule

// File: rtl/ps2_key_voice_alloc.sv
// ps2_key_voice_alloc: decodes PS/2 make/break bytes and allocates synth voices
// Ports: iCLK_50/iRST clock and sync reset; iByte/iByte_valid scancode stream;
// oVoice_on/oVoice_note per-voice gate and note; oEvt_* one-cycle gate-change event;
// oOctave current octave.
module ps2_key_voice_alloc
    import ps2_kbd_pkg::*;
#(
    parameter int NUM_VOICES     = 4,
    parameter int PREFIX_TIMEOUT = 2500000,
    parameter int OCT_RESET      = 4
) (
    input  logic                         iCLK_50,
    input  logic                         iRST,
    input  logic [7:0]                   iByte,
    input  logic                         iByte_valid,
    output logic [NUM_VOICES-1:0]        oVoice_on,
    output logic [NOTE_W*NUM_VOICES-1:0] oVoice_note,
    output logic                         oEvt_valid,
    output logic [2:0]                   oEvt_voice,
    output logic                         oEvt_on,
    output logic [2:0]                   oOctave
);
    localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    localparam int CW = $clog2(PREFIX_TIMEOUT) + 1;
    localparam logic [CW-1:0] TO_MAX = CW'(PREFIX_TIMEOUT - 1);

    dec_state_t st;
    logic [CW-1:0] cnt;
    logic hit;
    logic [3:0] idx;
    logic [NOTE_W-1:0] note;
    logic ev_mk, ev_bk;
    logic [NOTE_W-1:0] ev_note;
    logic [NUM_VOICES-1:0][NOTE_W-1:0] nt;
    logic [VW-1:0] sp, free_i, m_i, mk_v;
    logic has_free, dup;
    logic [NUM_VOICES-1:0] m_mask;

    ps2_scancode_to_note u_map (.code(iByte), .hit(hit), .idx(idx));

    assign note = NOTE_W'(oOctave) * NOTE_W'(12) + NOTE_W'(idx);
    assign oVoice_note = nt;

    // Stage 1: prefix decoding, octave keys, registered key event
    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            st      <= IDLE;
            cnt     <= '0;
            oOctave <= 3'(OCT_RESET);
            ev_mk   <= 1'b0;
            ev_bk   <= 1'b0;
            ev_note <= '0;
        end else begin
            ev_mk <= 1'b0;
            ev_bk <= 1'b0;
            if (iByte_valid) begin
                cnt <= '0;
                if (is_ctrl(iByte)) st <= IDLE;
                else case (st)
                    IDLE: begin
                        if (iByte == PFX_BRK) st <= BRK;
                        else if (iByte == PFX_EXT) st <= EXT;
                        else begin
                            if (iByte == KEY_OCT_DN && oOctave != 3'd0) oOctave <= oOctave - 3'd1;
                            if (iByte == KEY_OCT_UP && oOctave != 3'd7) oOctave <= oOctave + 3'd1;
                            ev_mk   <= hit;
                            ev_note <= note;
                        end
                    end
                    BRK: begin
                        st      <= IDLE;
                        ev_bk   <= hit;
                        ev_note <= note;
                    end
                    EXT:     st <= (iByte == PFX_BRK) ? EXT_BRK : IDLE;
                    default: st <= IDLE;
                endcase
            end else if (st == IDLE) begin
                cnt <= '0;
            end else if (cnt == TO_MAX) begin
                st  <= IDLE;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Downward scan so the lowest matching/free index wins
    always_comb begin
        dup      = 1'b0;
        has_free = 1'b0;
        free_i   = '0;
        m_i      = '0;
        m_mask   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (oVoice_on[v] && nt[v] == ev_note) begin
                dup       = 1'b1;
                m_i       = VW'(v);
                m_mask[v] = 1'b1;
            end
            if (!oVoice_on[v]) begin
                has_free = 1'b1;
                free_i   = VW'(v);
            end
        end
        mk_v = has_free ? free_i : sp;
    end

    // Stage 2: voice allocation and event reporting
    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            oVoice_on  <= '0;
            nt         <= '0;
            oEvt_valid <= 1'b0;
            oEvt_voice <= 3'd0;
            oEvt_on    <= 1'b0;
            sp         <= '0;
        end else begin
            oEvt_valid <= 1'b0;
            if (ev_mk && !dup) begin
                oVoice_on[mk_v] <= 1'b1;
                nt[mk_v]        <= ev_note;
                oEvt_valid      <= 1'b1;
                oEvt_voice      <= 3'(mk_v);
                oEvt_on         <= 1'b1;
                if (!has_free) sp <= (sp == VW'(NUM_VOICES - 1)) ? '0 : sp + 1'b1;
            end else if (ev_bk && dup) begin
                oVoice_on  <= oVoice_on & ~m_mask;
                oEvt_valid <= 1'b1;
                oEvt_voice <= 3'(m_i);
                oEvt_on    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_voice_alloc.sv
// tb_ps2_key_voice_alloc: directed self-checking bench for the voice allocator
module tb_ps2_key_voice_alloc;
    localparam int NV = 4;
    localparam int TO = 16;

    logic iCLK_50 = 1'b0;
    logic iRST = 1'b1;
    logic [7:0] iByte = 8'h00;
    logic iByte_valid = 1'b0;
    logic [NV-1:0] oVoice_on;
    logic [7*NV-1:0] oVoice_note;
    logic oEvt_valid;
    logic [2:0] oEvt_voice;
    logic oEvt_on;
    logic [2:0] oOctave;

    int tests = 0;
    int fails = 0;
    int ev_cnt = 0;
    logic [2:0] last_voice = 3'd0;
    logic last_on = 1'b0;

    ps2_key_voice_alloc #(.NUM_VOICES(NV), .PREFIX_TIMEOUT(TO), .OCT_RESET(4)) dut (
        .iCLK_50(iCLK_50), .iRST(iRST), .iByte(iByte), .iByte_valid(iByte_valid),
        .oVoice_on(oVoice_on), .oVoice_note(oVoice_note), .oEvt_valid(oEvt_valid),
        .oEvt_voice(oEvt_voice), .oEvt_on(oEvt_on), .oOctave(oOctave)
    );

    always #5 iCLK_50 = ~iCLK_50;

    always @(posedge iCLK_50) begin
        #1;
        if (oEvt_valid) begin
            ev_cnt++;
            last_voice = oEvt_voice;
            last_on = oEvt_on;
        end
    end

    task automatic do_reset();
        iRST = 1'b1;
        iByte_valid = 1'b0;
        repeat (2) @(negedge iCLK_50);
        iRST = 1'b0;
        @(negedge iCLK_50);
    endtask

    task automatic send(input logic [7:0] b);
        iByte = b;
        iByte_valid = 1'b1;
        @(negedge iCLK_50);
        iByte_valid = 1'b0;
        repeat (2) @(negedge iCLK_50);
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (oVoice_on !== 4'b0) begin fails++; $display("FAIL reset_on: got %b exp 0000", oVoice_on); end
        tests++; if (oVoice_note !== 28'd0) begin fails++; $display("FAIL reset_note: got %h exp 0", oVoice_note); end
        tests++; if ({oEvt_valid, oEvt_voice, oEvt_on} !== 5'd0) begin fails++; $display("FAIL reset_evt: got %b exp 00000", {oEvt_valid, oEvt_voice, oEvt_on}); end
        tests++; if (oOctave !== 3'd4) begin fails++; $display("FAIL reset_oct: got %0d exp 4", oOctave); end
    endtask

    task automatic test_make_break();
        int e0;
        do_reset();
        e0 = ev_cnt;
        send(8'h1C);
        tests++; if (oVoice_on !== 4'b0001 || oVoice_note[6:0] !== 7'd48) begin fails++; $display("FAIL make_1c: got on=%b note=%0d exp on=0001 note=48", oVoice_on, oVoice_note[6:0]); end
        tests++; if (ev_cnt - e0 !== 1 || last_voice !== 3'd0 || last_on !== 1'b1) begin fails++; $display("FAIL make_evt: got n=%0d v=%0d on=%b exp n=1 v=0 on=1", ev_cnt - e0, last_voice, last_on); end
        send(8'hF0);
        send(8'h1C);
        tests++; if (oVoice_on !== 4'b0000) begin fails++; $display("FAIL break_1c: got on=%b exp 0000", oVoice_on); end
        tests++; if (ev_cnt - e0 !== 2 || last_voice !== 3'd0 || last_on !== 1'b0) begin fails++; $display("FAIL break_evt: got n=%0d v=%0d on=%b exp n=2 v=0 on=0", ev_cnt - e0, last_voice, last_on); end
        send(8'hF0);
        send(8'h1D);
        tests++; if (ev_cnt - e0 !== 2) begin fails++; $display("FAIL break_nomatch: got n=%0d exp 2", ev_cnt - e0); end
    endtask

    task automatic test_steal();
        do_reset();
        send(8'h1C); send(8'h1D); send(8'h1B); send(8'h24);
        tests++; if (oVoice_on !== 4'b1111 || oVoice_note !== {7'd51, 7'd50, 7'd49, 7'd48}) begin fails++; $display("FAIL fill: got on=%b notes=%h exp 1111 notes=%h", oVoice_on, oVoice_note, {7'd51, 7'd50, 7'd49, 7'd48}); end
        send(8'h23);
        tests++; if (oVoice_note !== {7'd51, 7'd50, 7'd49, 7'd52} || last_voice !== 3'd0 || last_on !== 1'b1) begin fails++; $display("FAIL steal0: got notes=%h v=%0d exp notes=%h v=0", oVoice_note, last_voice, {7'd51, 7'd50, 7'd49, 7'd52}); end
        send(8'h2B);
        tests++; if (oVoice_on !== 4'b1111 || oVoice_note !== {7'd51, 7'd50, 7'd53, 7'd52} || last_voice !== 3'd1) begin fails++; $display("FAIL steal1: got on=%b notes=%h v=%0d exp 1111 notes=%h v=1", oVoice_on, oVoice_note, last_voice, {7'd51, 7'd50, 7'd53, 7'd52}); end
    endtask

    task automatic test_repeat();
        int e0;
        do_reset();
        e0 = ev_cnt;
        repeat (5) send(8'h1C);
        tests++; if (ev_cnt - e0 !== 1 || oVoice_on !== 4'b0001) begin fails++; $display("FAIL repeat: got n=%0d on=%b exp n=1 on=0001", ev_cnt - e0, oVoice_on); end
    endtask

    task automatic test_octave();
        do_reset();
        repeat (4) send(8'h22);
        tests++; if (oOctave !== 3'd7) begin fails++; $display("FAIL oct_up_sat: got %0d exp 7", oOctave); end
        send(8'h42);
        tests++; if (oVoice_on !== 4'b0001 || oVoice_note[6:0] !== 7'd96) begin fails++; $display("FAIL note_96: got on=%b note=%0d exp 0001 96", oVoice_on, oVoice_note[6:0]); end
        repeat (8) send(8'h1A);
        tests++; if (oOctave !== 3'd0 || oVoice_note[6:0] !== 7'd96) begin fails++; $display("FAIL oct_dn_sat: got oct=%0d note=%0d exp 0 96", oOctave, oVoice_note[6:0]); end
        send(8'h1D);
        tests++; if (oVoice_note[13:7] !== 7'd1) begin fails++; $display("FAIL oct0_note: got %0d exp 1", oVoice_note[13:7]); end
    endtask

    task automatic test_ext_ctrl();
        int e0;
        do_reset();
        e0 = ev_cnt;
        send(8'hE0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h1C);
        tests++; if (ev_cnt - e0 !== 0 || oVoice_on !== 4'b0000) begin fails++; $display("FAIL ext_drop: got n=%0d on=%b exp n=0 on=0000", ev_cnt - e0, oVoice_on); end
        send(8'h1D);
        tests++; if (oVoice_on !== 4'b0001 || oVoice_note[6:0] !== 7'd49) begin fails++; $display("FAIL after_ext: got on=%b note=%0d exp 0001 49", oVoice_on, oVoice_note[6:0]); end
        send(8'hF0); send(8'hAA); send(8'h1D);
        tests++; if (oVoice_on !== 4'b0001) begin fails++; $display("FAIL ctrl_idle: got on=%b exp 0001", oVoice_on); end
    endtask

    task automatic test_back_to_back();
        int e0;
        do_reset();
        e0 = ev_cnt;
        iByte = 8'h1C; iByte_valid = 1'b1;
        @(negedge iCLK_50);
        iByte = 8'h1D;
        @(negedge iCLK_50);
        iByte_valid = 1'b0;
        repeat (2) @(negedge iCLK_50);
        tests++; if (ev_cnt - e0 !== 2 || oVoice_on !== 4'b0011 || oVoice_note[13:0] !== {7'd49, 7'd48}) begin fails++; $display("FAIL b2b: got n=%0d on=%b notes=%h exp n=2 on=0011", ev_cnt - e0, oVoice_on, oVoice_note[13:0]); end
    endtask

    task automatic test_timeout();
        do_reset();
        send(8'hF0);
        repeat (TO + 4) @(negedge iCLK_50);
        send(8'h1C);
        tests++; if (oVoice_on !== 4'b0001 || oVoice_note[6:0] !== 7'd48) begin fails++; $display("FAIL timeout_make: got on=%b note=%0d exp 0001 48", oVoice_on, oVoice_note[6:0]); end
        send(8'hF0);
        repeat (5) @(negedge iCLK_50);
        send(8'h1C);
        tests++; if (oVoice_on !== 4'b0000) begin fails++; $display("FAIL short_wait_break: got on=%b exp 0000", oVoice_on); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'hF0);
        do_reset();
        send(8'h1C);
        tests++; if (oVoice_on !== 4'b0001) begin fails++; $display("FAIL reset_mid: got on=%b exp 0001", oVoice_on); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_steal();
        test_repeat();
        test_octave();
        test_ext_ctrl();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
